// File: rtl/jtag_cmd_bridge.sv
// JTAG-to-register-bus command bridge: bytes written through a JTAG data
// register are decoded as NOP/WRITE/READ/CONTROL commands and run on a simple
// req/ack bus in the clk domain.
//
// Ports:
//   clk, aclr (async, active-low, resets both domains), tck
//   upd_data/upd_valid : byte from JTAG Update-DR (tck domain, quasi-static)
//   rd_data            : last completed read byte (JTAG capture input)
//   bus_req/bus_we/bus_addr/bus_wdata/bus_rdata/bus_ack : register bus
//   busy               : FSM not in IDLE
//   err_flags          : sticky {timeout, overrun, protocol}
//
// Optional feature: define JTAG_CMD_BRIDGE_TIMEOUT_EN to abort bus cycles
// that see no bus_ack within TIMEOUT clk cycles.
module jtag_cmd_bridge #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          tck,
  input  logic [DW-1:0] upd_data,
  input  logic          upd_valid,
  output logic [DW-1:0] rd_data,
  output logic          bus_req,
  output logic          bus_we,
  output logic [DW-3:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          busy,
  output logic [2:0]    err_flags
);

  localparam int AW = DW - 2;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CTRL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_DATA = 2'd1,
    BUS_WR   = 2'd2,
    BUS_RD   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // tck domain: a single toggle flop marks each new byte. The byte itself
  // is held stable by the JTAG side until the next update, so only this
  // one bit has to cross domains.
  // ---------------------------------------------------------------------
  logic tog_q;

  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr)          tog_q <= 1'b0;
    else if (upd_valid) tog_q <= ~tog_q;
  end

  // ---------------------------------------------------------------------
  // clk domain: synchronizer plus edge detector -> one-cycle byte strobe
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   strobe;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_q};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] ^ edge_q;

  // Command decode straight off the quasi-static JTAG byte
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;

  assign cmd_op   = upd_data[DW-1:DW-2];
  assign cmd_addr = upd_data[AW-1:0];

  // ---------------------------------------------------------------------
  // Bus timeout
  // ---------------------------------------------------------------------
  state_t state_q;
  logic   in_bus;
  logic   to_hit;

  assign in_bus = (state_q == BUS_WR) || (state_q == BUS_RD);

`ifdef JTAG_CMD_BRIDGE_TIMEOUT_EN
  // Counter reads k-1 in the k-th cycle of a bus transaction, so the
  // abort fires in the TIMEOUT-th cycle with bus_req still high.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)       cnt_q <= '0;
    else if (in_bus) cnt_q <= cnt_q + 8'd1;
    else             cnt_q <= '0;
  end

  assign to_hit = in_bus && (cnt_q == TO_LAST);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign to_hit         = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Sticky error flags {timeout, overrun, protocol}; a set in the same
  // cycle as a clear survives.
  // ---------------------------------------------------------------------
  logic [2:0] err_q;
  logic [2:0] err_set;
  logic       err_clr;
  logic [2:0] err_d;

  always_comb begin
    err_set = 3'b000;
    err_clr = 1'b0;
    if (state_q == IDLE && strobe && cmd_op == OP_CTRL) begin
      if (cmd_addr == '0) err_clr    = 1'b1;
      else                err_set[0] = 1'b1;
    end
    if (in_bus && strobe)    err_set[1] = 1'b1;
    if (to_hit && !bus_ack)  err_set[2] = 1'b1;
    err_d = (err_clr ? 3'b000 : err_q) | err_set;
  end

  // ---------------------------------------------------------------------
  // Command FSM with registered bus outputs
  // ---------------------------------------------------------------------
  logic          bus_req_q;
  logic          bus_we_q;
  logic [AW-1:0] bus_addr_q;
  logic [DW-1:0] bus_wdata_q;
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_data_q   <= '0;
      err_q       <= 3'b000;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (strobe) begin
            case (cmd_op)
              OP_WRITE: begin
                bus_addr_q <= cmd_addr;
                bus_we_q   <= 1'b1;
                state_q    <= GET_DATA;
              end
              OP_READ: begin
                bus_addr_q <= cmd_addr;
                bus_we_q   <= 1'b0;
                bus_req_q  <= 1'b1;
                state_q    <= BUS_RD;
              end
              default: ; // NOP and CONTROL only affect err_q
            endcase
          end
        end
        GET_DATA: begin
          if (strobe) begin
            bus_wdata_q <= upd_data;
            bus_req_q   <= 1'b1;
            state_q     <= BUS_WR;
          end
        end
        BUS_WR, BUS_RD: begin
          // Bytes arriving here are dropped (flagged as overrun above);
          // an ack in the terminal cycle takes priority over the timeout.
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
            if (state_q == BUS_RD) rd_data_q <= bus_rdata;
          end else if (to_hit) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
            if (state_q == BUS_RD) rd_data_q <= '1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rd_data   = rd_data_q;
  assign err_flags = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_jtag_cmd_bridge.sv
module tb_jtag_cmd_bridge;

  logic       clk = 1'b0;
  logic       tck = 1'b0;
  logic       aclr = 1'b0;
  logic [7:0] upd_data = 8'h00;
  logic       upd_valid = 1'b0;
  logic [7:0] rd_data;
  logic       bus_req;
  logic       bus_we;
  logic [5:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata = 8'h00;
  logic       bus_ack = 1'b0;
  logic       busy;
  logic [2:0] err_flags;

  int tests_run = 0;
  int tests_failed = 0;

  jtag_cmd_bridge #(.DW(8), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .tck       (tck),
    .upd_data  (upd_data),
    .upd_valid (upd_valid),
    .rd_data   (rd_data),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .busy      (busy),
    .err_flags (err_flags)
  );

  always #5  clk = ~clk;
  always #20 tck = ~tck;

  // One JTAG update: upd_valid high for one tck, byte left stable afterwards
  task automatic send_byte(input logic [7:0] b);
    @(negedge tck);
    upd_data  = b;
    upd_valid = 1'b1;
    @(negedge tck);
    upd_valid = 1'b0;
  endtask

  // Bus slave: wait (bounded) for bus_req, ack in its n-th high cycle,
  // then watch 3 more cycles. hi = total cycles bus_req was seen high.
  task automatic ack_after(input int n, input logic [7:0] rdata, output int hi,
                           output logic [5:0] a0, output logic we0,
                           output logic [7:0] wd0, output bit moved);
    hi = 0; moved = 0; a0 = '0; we0 = 1'b0; wd0 = '0;
    for (int i = 0; i < 60 && bus_req !== 1'b1; i++) @(negedge clk);
    if (bus_req !== 1'b1) return;
    a0 = bus_addr; we0 = bus_we; wd0 = bus_wdata; hi = 1;
    while (hi < n) begin
      @(negedge clk);
      if (bus_req !== 1'b1) break;
      hi++;
      if (bus_addr !== a0 || bus_we !== we0 || bus_wdata !== wd0) moved = 1;
    end
    bus_rdata = rdata;
    bus_ack   = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    repeat (3) begin
      if (bus_req === 1'b1) hi++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if ({bus_req, bus_we, busy} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctl: req/we/busy=%b expected 000", {bus_req, bus_we, busy});
    end
    tests_run++;
    if ({bus_addr, bus_wdata, rd_data, err_flags} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h rd=%h err=%b expected all 0",
               bus_addr, bus_wdata, rd_data, err_flags);
    end
    @(negedge clk);
    aclr = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write;
    int hi; logic [5:0] a0; logic we0; logic [7:0] wd0; bit moved;
    send_byte(8'h45);
    send_byte(8'hA5);
    ack_after(3, 8'h00, hi, a0, we0, wd0, moved);
    tests_run++;
    if (hi !== 3) begin
      tests_failed++; $display("FAIL write_req_len: got %0d cycles expected 3", hi);
    end
    tests_run++;
    if ({a0, we0, wd0} !== {6'h05, 1'b1, 8'hA5}) begin
      tests_failed++;
      $display("FAIL write_fields: addr=%h we=%b wdata=%h expected 05 1 a5", a0, we0, wd0);
    end
    tests_run++;
    if (moved !== 1'b0) begin
      tests_failed++; $display("FAIL write_stable: bus fields changed during req");
    end
    tests_run++;
    if ({err_flags, busy, rd_data} !== {3'b000, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL write_after: err=%b busy=%b rd=%h expected 000 0 00", err_flags, busy, rd_data);
    end
  endtask

  task automatic test_read;
    int hi; logic [5:0] a0; logic we0; logic [7:0] wd0; bit moved;
    send_byte(8'h8A);
    ack_after(2, 8'h3C, hi, a0, we0, wd0, moved);
    tests_run++;
    if ({hi, a0, we0} !== {32'd2, 6'h0A, 1'b0}) begin
      tests_failed++;
      $display("FAIL read_fields: cycles=%0d addr=%h we=%b expected 2 0a 0", hi, a0, we0);
    end
    tests_run++;
    if ({rd_data, busy} !== {8'h3C, 1'b0}) begin
      tests_failed++;
      $display("FAIL read_result: rd=%h busy=%b expected 3c 0", rd_data, busy);
    end
  endtask

  task automatic test_nop;
    int cnt = 0;
    send_byte(8'h00);
    repeat (10) begin @(negedge clk); if (bus_req === 1'b1 || busy === 1'b1) cnt++; end
    tests_run++;
    if ({cnt, err_flags} !== {32'd0, 3'b000}) begin
      tests_failed++;
      $display("FAIL nop: active cycles=%0d err=%b expected 0 000", cnt, err_flags);
    end
  endtask

  task automatic test_protocol;
    int cnt = 0;
    send_byte(8'hC3);
    repeat (10) begin @(negedge clk); if (bus_req === 1'b1 || busy === 1'b1) cnt++; end
    tests_run++;
    if ({cnt, err_flags} !== {32'd0, 3'b001}) begin
      tests_failed++;
      $display("FAIL protocol: active cycles=%0d err=%b expected 0 001", cnt, err_flags);
    end
  endtask

  task automatic test_overrun_clear;
    int hi; logic [5:0] a0; logic we0; logic [7:0] wd0; bit moved;
    send_byte(8'h81);
    for (int i = 0; i < 60 && bus_req !== 1'b1; i++) @(negedge clk);
    send_byte(8'h00);
    repeat (4) @(negedge clk);
    tests_run++;
    if ({err_flags, bus_req} !== {3'b011, 1'b1}) begin
      tests_failed++;
      $display("FAIL overrun_flag: err=%b req=%b expected 011 1", err_flags, bus_req);
    end
    ack_after(1, 8'h77, hi, a0, we0, wd0, moved);
    tests_run++;
    if ({hi, a0, we0, moved} !== {32'd1, 6'h01, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL overrun_txn: cycles=%0d addr=%h we=%b moved=%b expected 1 01 0 0",
               hi, a0, we0, moved);
    end
    tests_run++;
    if ({rd_data, busy} !== {8'h77, 1'b0}) begin
      tests_failed++;
      $display("FAIL overrun_rd: rd=%h busy=%b expected 77 0", rd_data, busy);
    end
    send_byte(8'hC0);
    repeat (6) @(negedge clk);
    tests_run++;
    if (err_flags !== 3'b000) begin
      tests_failed++; $display("FAIL ctrl_clear: err=%b expected 000", err_flags);
    end
  endtask

  task automatic test_timeout;
    int cnt = 0;
    int hi; logic [5:0] a0; logic we0; logic [7:0] wd0; bit moved;
    send_byte(8'h85);
    repeat (40) begin @(negedge clk); if (bus_req === 1'b1) cnt++; end
`ifdef JTAG_CMD_BRIDGE_TIMEOUT_EN
    tests_run++;
    if (cnt !== 10) begin
      tests_failed++; $display("FAIL timeout_len: req cycles=%0d expected 10", cnt);
    end
    tests_run++;
    if ({err_flags, rd_data, busy} !== {3'b100, 8'hFF, 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_state: err=%b rd=%h busy=%b expected 100 ff 0", err_flags, rd_data, busy);
    end
    send_byte(8'hC0);
    repeat (6) @(negedge clk);
    send_byte(8'h86);
    ack_after(10, 8'h11, hi, a0, we0, wd0, moved);
    tests_run++;
    if ({hi, err_flags, rd_data} !== {32'd10, 3'b000, 8'h11}) begin
      tests_failed++;
      $display("FAIL ack_wins: cycles=%0d err=%b rd=%h expected 10 000 11", hi, err_flags, rd_data);
    end
`else
    tests_run++;
    if (cnt < 35 || bus_req !== 1'b1 || busy !== 1'b1 || err_flags !== 3'b000) begin
      tests_failed++;
      $display("FAIL no_timeout: req cycles=%0d req=%b busy=%b err=%b expected >=35 1 1 000",
               cnt, bus_req, busy, err_flags);
    end
    ack_after(1, 8'h5A, hi, a0, we0, wd0, moved);
    tests_run++;
    if ({a0, rd_data, busy, err_flags} !== {6'h05, 8'h5A, 1'b0, 3'b000}) begin
      tests_failed++;
      $display("FAIL late_ack: addr=%h rd=%h busy=%b err=%b expected 05 5a 0 000",
               a0, rd_data, busy, err_flags);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int cnt = 0;
    send_byte(8'h47);
    send_byte(8'h12);
    for (int i = 0; i < 60 && bus_req !== 1'b1; i++) @(negedge clk);
    tests_run++;
    if ({bus_req, bus_addr, bus_wdata} !== {1'b1, 6'h07, 8'h12}) begin
      tests_failed++;
      $display("FAIL pre_reset: req=%b addr=%h wdata=%h expected 1 07 12", bus_req, bus_addr, bus_wdata);
    end
    @(negedge clk);
    #2 aclr = 1'b0;
    #1;
    tests_run++;
    if ({bus_req, bus_we, busy, bus_addr, bus_wdata, rd_data, err_flags} !== 28'd0) begin
      tests_failed++;
      $display("FAIL async_reset: req=%b we=%b busy=%b addr=%h wd=%h rd=%h err=%b expected all 0",
               bus_req, bus_we, busy, bus_addr, bus_wdata, rd_data, err_flags);
    end
    #5 aclr = 1'b1;
    repeat (20) begin @(negedge clk); if (bus_req === 1'b1 || busy === 1'b1) cnt++; end
    tests_run++;
    if (cnt !== 0) begin
      tests_failed++; $display("FAIL reset_drop: active cycles after reset=%0d expected 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nop();
    test_protocol();
    test_overrun_clear();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jtag_cmd_bridge.md
JTAG_CMD_BRIDGE -- requirements
Module: jtag_cmd_bridge

Interface
REQ-001 Parameter DW, 8, JTAG data-byte width; address width AW = DW-2.
REQ-002 Parameter SYNC_STAGES, 2, synchronizer depth in clk domain (min 2).
REQ-003 Parameter TIMEOUT, 255, max clk cycles waiting for bus_ack (1..255).
REQ-004 clk  input  1  system clock; all bus and FSM logic on posedge clk.
REQ-005 aclr  input  1  reset, asynchronous, active-low; resets both tck and clk domains.
REQ-006 tck  input  1  JTAG clock; only the update toggle flop lives here.
REQ-007 upd_data  input  DW  byte from JTAG write register; stable from upd_valid until next update.
REQ-008 upd_valid  input  1  tck-domain qualifier, high for one tck when a new byte is latched (Update-DR with WRITE).
REQ-009 rd_data  output  DW  read-back byte for the JTAG read register capture input.
REQ-010 bus_req  output  1  bus request, held until bus_ack or timeout.
REQ-011 bus_we  output  1  1 = write, 0 = read; valid while bus_req.
REQ-012 bus_addr  output  AW  register address; valid while bus_req.
REQ-013 bus_wdata  output  DW  write data; valid while bus_req and bus_we.
REQ-014 bus_rdata  input  DW  read data, sampled in the cycle bus_ack=1.
REQ-015 bus_ack  input  1  one-cycle completion pulse from slave.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 err_flags  output  3  sticky {timeout, overrun, protocol}.

Function
REQ-018 Toggle flop (tck) SHALL invert on each posedge tck with upd_valid=1.
REQ-019 Toggle SHALL pass SYNC_STAGES flops on clk, then an edge detector producing a one-clk byte strobe; upd_data SHALL be captured on that strobe (latency SYNC_STAGES+1 clk from toggle change).
REQ-020 Command byte: op = bits[DW-1:DW-2], addr = bits[AW-1:0]; op 00 NOP, 01 WRITE, 10 READ, 11 CONTROL.
REQ-021 FSM states IDLE, GET_DATA, BUS_WR, BUS_RD; reset state IDLE.
REQ-022 IDLE + strobe: NOP -> stay; WRITE -> latch addr, GET_DATA; READ -> latch addr, BUS_RD; CONTROL addr=0 -> clear err_flags, stay; CONTROL addr!=0 -> set protocol flag, stay.
REQ-023 GET_DATA + strobe: byte -> bus_wdata, go BUS_WR next clk.
REQ-024 BUS_WR/BUS_RD: bus_req=1 from state entry; on bus_ack, bus_req=0 same-cycle registered deassert next clk, return IDLE.
REQ-025 BUS_RD ack: rd_data <= bus_rdata, held until next completed read or reset.
REQ-026 Strobe during BUS_WR/BUS_RD: byte dropped, overrun flag set, transaction unaffected.
REQ-027 bus_addr/bus_we/bus_wdata SHALL not change while bus_req=1.
REQ-028 Error flags sticky; cleared only by CONTROL addr=0 or reset; clear and new set in same cycle -> set wins.

Reset
REQ-029 On aclr low: toggle=0, sync flops=0, FSM=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rd_data=0, err_flags=0, busy=0.
REQ-030 Reset mid-transaction SHALL drop bus_req immediately (asynchronously); no pending command survives.

Configuration
REQ-031 Macro JTAG_CMD_BRIDGE_TIMEOUT_EN defined: counter runs in BUS_WR/BUS_RD; on reaching TIMEOUT without ack, drop bus_req, set timeout flag, rd_data=all-ones for reads, go IDLE; ack in the terminal cycle wins over timeout.
REQ-032 Macro undefined: no counter, FSM waits for bus_ack indefinitely, timeout flag tied 0.

Verification
REQ-033 Bytes 0x45, 0xA5, ack after 3 clk -> one write, addr=0x05, wdata=0xA5, bus_req high 3 clk, err_flags=000.
REQ-034 Byte 0x8A, ack with bus_rdata=0x3C -> bus_we=0, addr=0x0A, rd_data=0x3C, busy low after ack.
REQ-035 Byte 0x81 then 0x00 sent before ack -> overrun set, read completes normally, 0xC0 clears err_flags to 000.
REQ-036 Byte 0xC3 -> protocol flag set, FSM stays IDLE, no bus_req.
REQ-037 TIMEOUT_EN, TIMEOUT=10, READ with no ack -> bus_req drops after 10 clk, timeout flag set, rd_data=0xFF; aclr pulse mid-BUS_WR -> bus_req=0 at once, all outputs at reset values.
